// File: rtl/tuart_tx_cfg.sv
// tuart_tx_cfg -- configurable UART transmitter for the logic-analyser host link.
//
// Sends a transaction of 1..CMD_WORDS words, low word first, on a single
// serial line. The bit divisor, parity mode, stop-bit count and word count
// are captured when a transaction is accepted and held until it finishes.
// A high xoff_i at the end of a word's stop period parks the line (idle high)
// before the next word. done_o pulses once when the last stop bit ends.
//
// Ports:
//   clk_i     system clock
//   rst_i     synchronous active-high reset
//   stb_i     transaction request, accepted when stb_i && rdy_o
//   rdy_o     idle, able to accept a transaction
//   data_i    payload, word k = data_i[k*WORD_BITS +: WORD_BITS]
//   nwords_i  number of words to send minus one
//   div_i     clock cycles per bit (0 and 1 behave as 2)
//   parity_i  00 none, 01 odd, 10 even, 11 none
//   stop2_i   0: one stop bit, 1: two stop bits
//   xoff_i    host flow control, pauses between words
//   tx_o      serial line, idle high
//   done_o    one-cycle pulse at transaction completion
module tuart_tx_cfg #(
  parameter int WORD_BITS = 8,
  parameter int CMD_WORDS = 4,
  parameter int DIV_BITS  = 16
) (
  input  logic                           clk_i,
  input  logic                           rst_i,
  input  logic                           stb_i,
  output logic                           rdy_o,
  input  logic [CMD_WORDS*WORD_BITS-1:0] data_i,
  input  logic [$clog2(CMD_WORDS)-1:0]   nwords_i,
  input  logic [DIV_BITS-1:0]            div_i,
  input  logic [1:0]                     parity_i,
  input  logic                           stop2_i,
  input  logic                           xoff_i,
  output logic                           tx_o,
  output logic                           done_o
);

  localparam int NW_W  = $clog2(CMD_WORDS);
  localparam int BIT_W = $clog2(WORD_BITS);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PARITY,
    S_STOP,
    S_HOLD
  } state_t;

  // Reload value for the bit counter: divisors below 2 are clamped to 2.
  function automatic logic [DIV_BITS-1:0] eff_divm1(input logic [DIV_BITS-1:0] d);
    if (d < DIV_BITS'(2)) begin
      return DIV_BITS'(1);
    end
    return d - 1'b1;
  endfunction

  // Even parity is the XOR of the data bits; odd is its inverse.
  function automatic logic par_bit(input logic [WORD_BITS-1:0] w, input logic odd);
    return (^w) ^ odd;
  endfunction

  state_t                         state_q, state_n;
  logic [DIV_BITS-1:0]            cnt_q, cnt_n;
  logic [BIT_W-1:0]               bit_q, bit_n;
  logic [NW_W-1:0]                widx_q, widx_n;
  logic                           tx_q, tx_n;
  logic                           done_q, done_n;
  logic                           accept;

  // Per-transaction settings, captured at accept.
  logic [CMD_WORDS*WORD_BITS-1:0] data_q;
  logic [NW_W-1:0]                nw_q;
  logic [DIV_BITS-1:0]            divm1_q;
  logic                           par_en_q;
  logic                           par_odd_q;
  logic                           stop2_q;

  logic [WORD_BITS-1:0]           word_n;

  always_comb begin
    state_n = state_q;
    cnt_n   = cnt_q;
    bit_n   = bit_q;
    widx_n  = widx_q;
    done_n  = 1'b0;
    accept  = 1'b0;
    tx_n    = 1'b1;
    word_n  = '0;

    unique case (state_q)
      S_IDLE: begin
        if (stb_i) begin
          accept  = 1'b1;
          state_n = S_START;
          cnt_n   = eff_divm1(div_i);
          widx_n  = '0;
          bit_n   = '0;
        end
      end
      S_START: begin
        if (cnt_q == '0) begin
          state_n = S_DATA;
          cnt_n   = divm1_q;
          bit_n   = '0;
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      S_DATA: begin
        if (cnt_q == '0) begin
          cnt_n = divm1_q;
          if (bit_q == BIT_W'(WORD_BITS - 1)) begin
            bit_n   = '0;
            state_n = par_en_q ? S_PARITY : S_STOP;
          end else begin
            bit_n = bit_q + 1'b1;
          end
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      S_PARITY: begin
        if (cnt_q == '0) begin
          state_n = S_STOP;
          cnt_n   = divm1_q;
          bit_n   = '0;
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      S_STOP: begin
        // bit_q counts stop bits so two stop bits reuse the same counter.
        if (cnt_q == '0) begin
          if (stop2_q && (bit_q == '0)) begin
            bit_n = BIT_W'(1);
            cnt_n = divm1_q;
          end else if (widx_q == nw_q) begin
            state_n = S_IDLE;
            done_n  = 1'b1;
          end else if (xoff_i) begin
            state_n = S_HOLD;
          end else begin
            state_n = S_START;
            cnt_n   = divm1_q;
            widx_n  = widx_q + 1'b1;
          end
        end else begin
          cnt_n = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (!xoff_i) begin
          state_n = S_START;
          cnt_n   = divm1_q;
          widx_n  = widx_q + 1'b1;
        end
      end
      default: begin
        state_n = S_IDLE;
      end
    endcase

    // Line level is registered from the next state so tx_o is glitch-free.
    word_n = data_q[int'(widx_n)*WORD_BITS +: WORD_BITS];
    unique case (state_n)
      S_START:  tx_n = 1'b0;
      S_DATA:   tx_n = word_n[bit_n];
      S_PARITY: tx_n = par_bit(word_n, par_odd_q);
      default:  tx_n = 1'b1;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q <= S_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      widx_q  <= '0;
      tx_q    <= 1'b1;
      done_q  <= 1'b0;
    end else begin
      state_q <= state_n;
      cnt_q   <= cnt_n;
      bit_q   <= bit_n;
      widx_q  <= widx_n;
      tx_q    <= tx_n;
      done_q  <= done_n;
    end
  end

  always_ff @(posedge clk_i) begin
    if (accept) begin
      data_q    <= data_i;
      nw_q      <= nwords_i;
      divm1_q   <= eff_divm1(div_i);
      par_en_q  <= (parity_i == 2'b01) || (parity_i == 2'b10);
      par_odd_q <= (parity_i == 2'b01);
      stop2_q   <= stop2_i;
    end
  end

  assign rdy_o  = (state_q == S_IDLE);
  assign tx_o   = tx_q;
  assign done_o = done_q;

endmodule

// File: tb/tb_tuart_tx_cfg.sv
// Testbench for tuart_tx_cfg: stimulus queues expected transactions, a
// monitor decodes the serial line against them.
module tb_tuart_tx_cfg;

  logic        clk = 1'b0;
  logic        rst_i;
  logic        stb_i;
  logic        rdy_o;
  logic [31:0] data_i;
  logic [1:0]  nwords_i;
  logic [15:0] div_i;
  logic [1:0]  parity_i;
  logic        stop2_i;
  logic        xoff_i;
  logic        tx_o;
  logic        done_o;

  always #5 clk = ~clk;

  tuart_tx_cfg #(
    .WORD_BITS(8),
    .CMD_WORDS(4),
    .DIV_BITS (16)
  ) dut (
    .clk_i   (clk),
    .rst_i   (rst_i),
    .stb_i   (stb_i),
    .rdy_o   (rdy_o),
    .data_i  (data_i),
    .nwords_i(nwords_i),
    .div_i   (div_i),
    .parity_i(parity_i),
    .stop2_i (stop2_i),
    .xoff_i  (xoff_i),
    .tx_o    (tx_o),
    .done_o  (done_o)
  );

  typedef struct {
    logic [31:0] data;
    int          nw;
    int          div;
    int          par;
    bit          st2;
    int          gap1;  // idle cycles expected before word 1
  } txn_t;

  txn_t exp_q[$];
  int   errors   = 0;
  int   checks   = 0;
  int   done_cnt = 0;
  int   n_txn    = 0;
  bit   mon_en   = 1'b1;

  task automatic chk(input bit ok, input string name, input int act, input int exp);
    checks++;
    if (!ok) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic scramble();
    data_i   = $urandom;
    nwords_i = 2'($urandom);
    div_i    = 16'($urandom);
    parity_i = 2'($urandom);
    stop2_i  = 1'($urandom);
  endtask

  task automatic wait_rdy();
    int to;
    to = 0;
    while (rdy_o !== 1'b1 && to < 10000) begin
      @(negedge clk);
      to++;
    end
    if (to >= 10000) chk(1'b0, "rdy_timeout", to, 0);
  endtask

  // Issues one transaction; returns 1 ns after the accepting edge.
  task automatic send(input logic [31:0] d, input int nw, input int dv, input int par,
                      input bit st2, input int gap1, input bit push);
    txn_t t;
    @(negedge clk);
    wait_rdy();
    data_i   = d;
    nwords_i = 2'(nw);
    div_i    = 16'(dv);
    parity_i = 2'(par);
    stop2_i  = st2;
    stb_i    = 1'b1;
    if (push) begin
      t.data = d; t.nw = nw; t.div = dv; t.par = par; t.st2 = st2; t.gap1 = gap1;
      exp_q.push_back(t);
      n_txn++;
    end
    @(posedge clk);
    #1;
    stb_i = 1'b0;
    scramble();
  endtask

  task automatic wait_idle();
    @(negedge clk);
    wait_rdy();
    repeat (3) @(negedge clk);
  endtask

  always @(negedge clk) begin
    if (done_o === 1'b1) done_cnt++;
  end

  // Monitor: decodes frames from the line and compares with the queue.
  initial begin : monitor
    txn_t       t;
    bit         bq[$];
    logic [7:0] wv;
    int         d, gap, errs, ones, eg;
    forever begin
      @(negedge clk);
      if (mon_en && tx_o === 1'b0) begin
        if (exp_q.size() == 0) begin
          chk(1'b0, "unexpected_start", 0, 1);
        end else begin
          t = exp_q.pop_front();
          d = (t.div < 2) ? 2 : t.div;
          for (int w = 0; w <= t.nw; w++) begin
            if (w > 0) begin
              gap = 0;
              while (tx_o === 1'b1 && gap < 5000) begin
                gap++;
                @(negedge clk);
              end
              eg = (w == 1) ? t.gap1 : 0;
              chk(gap == eg, $sformatf("gap_w%0d", w), gap, eg);
            end
            wv   = t.data[w*8 +: 8];
            ones = $countones(wv);
            bq   = {};
            bq.push_back(1'b0);
            for (int i = 0; i < 8; i++) bq.push_back(wv[i]);
            if (t.par == 1) bq.push_back((ones % 2) == 0);
            else if (t.par == 2) bq.push_back((ones % 2) == 1);
            bq.push_back(1'b1);
            if (t.st2) bq.push_back(1'b1);
            for (int b = 0; b < bq.size(); b++) begin
              errs = 0;
              for (int c = 0; c < d; c++) begin
                if (tx_o !== bq[b] || done_o !== 1'b0) errs++;
                @(negedge clk);
              end
              chk(errs == 0, $sformatf("bit_w%0d_b%0d_lvl%0d", w, b, bq[b]), errs, 0);
            end
          end
          chk(done_o === 1'b1 && rdy_o === 1'b1 && tx_o === 1'b1, "done_pulse",
              {29'd0, done_o, rdy_o, tx_o}, 7);
        end
      end
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin : stim
    // Reset held with a pending strobe; the strobe is honoured on release.
    rst_i = 1'b1; stb_i = 1'b1; xoff_i = 1'b0;
    data_i = 32'h6E_4B_19_A5; nwords_i = 2'd0; div_i = 16'd5; parity_i = 2'd0; stop2_i = 1'b0;
    repeat (3) begin
      @(posedge clk);
      @(negedge clk);
      chk(tx_o === 1'b1 && rdy_o === 1'b1 && done_o === 1'b0, "reset_state",
          {29'd0, tx_o, rdy_o, done_o}, 6);
    end
    rst_i = 1'b0;
    exp_q.push_back('{data: data_i, nw: 0, div: 5, par: 0, st2: 1'b0, gap1: 0});
    n_txn++;
    @(posedge clk);
    #1;
    stb_i = 1'b0;
    scramble();
    wait_idle();

    // Four words, even parity, two stop bits.
    send(32'h0180FF00, 3, 4, 2, 1'b1, 0, 1'b1);
    wait_idle();

    // XOFF pause between words; a later XOFF on the last word is ignored.
    send(32'h9D27C35A, 1, 5, 0, 1'b0, 11, 1'b1);
    repeat (20) @(posedge clk);
    #1 xoff_i = 1'b1;
    repeat (40) @(posedge clk);
    #1;
    chk(tx_o === 1'b1 && rdy_o === 1'b0, "hold_line", {30'd0, tx_o, rdy_o}, 2);
    xoff_i = 1'b0;
    repeat (20) @(posedge clk);
    #1 xoff_i = 1'b1;
    wait_idle();
    xoff_i = 1'b0;

    // Divisor clamp.
    send(32'h0000003C, 0, 0, 0, 1'b0, 0, 1'b1);
    send(32'h0000003C, 0, 1, 0, 1'b0, 0, 1'b1);
    wait_idle();

    // Strobe while busy is ignored.
    send(32'h5A17E2C4, 3, 3, 1, 1'b0, 0, 1'b1);
    repeat (15) @(posedge clk);
    #1;
    stb_i  = 1'b1;
    data_i = 32'hFFFFFFFF;
    @(posedge clk);
    #1;
    stb_i = 1'b0;
    chk(rdy_o === 1'b0, "busy_rdy", {31'd0, rdy_o}, 0);
    wait_idle();
    repeat (30) @(negedge clk);

    // Reset during data bit 3.
    mon_en = 1'b0;
    send(32'h000000A5, 0, 5, 0, 1'b0, 0, 1'b0);
    repeat (22) @(posedge clk);
    #1 rst_i = 1'b1;
    @(negedge clk);
    chk(tx_o === 1'b0, "pre_reset_bit3", {31'd0, tx_o}, 0);
    @(posedge clk);
    @(negedge clk);
    chk(tx_o === 1'b1 && rdy_o === 1'b1 && done_o === 1'b0, "reset_midframe",
        {29'd0, tx_o, rdy_o, done_o}, 6);
    rst_i = 1'b0;
    repeat (5) @(negedge clk);
    mon_en = 1'b1;
    send(32'h00000096, 0, 3, 2, 1'b1, 0, 1'b1);
    wait_idle();

    // Random back-to-back transactions (accepts may land on the done cycle).
    for (int k = 0; k < 20; k++) begin
      send($urandom, $urandom_range(0, 3), $urandom_range(0, 6), $urandom_range(0, 3),
           1'($urandom_range(0, 1)), 0, 1'b1);
    end
    wait_idle();
    repeat (10) @(negedge clk);

    chk(done_cnt == n_txn, "done_count", done_cnt, n_txn);
    chk(exp_q.size() == 0, "queue_empty", exp_q.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/tuart_tx_cfg.md
Name: tuart_tx_cfg

Overview:
- Parametrised next-generation UART transmitter for the logic-analyser host link. Sends a command/response of 1..CMD_WORDS words, low word first.
- Adds per-transaction settings over a fixed-rate transmitter: runtime bit divisor, parity mode, stop-bit count and word count, all latched at handshake.
- Adds an XOFF pause between words and a completion pulse.
- Sits between the readout/command path and the physical tx pin.

Parameters:
- WORD_BITS, 8, data bits per UART frame (5..9).
- CMD_WORDS, 4, maximum words per transaction (>=2).
- DIV_BITS, 16, width of runtime divisor (clock cycles per bit).

Ports:
- clk_i  in  1  system clock.
- rst_i  in  1  synchronous active-high reset.
- stb_i  in  1  transaction request; accepted when stb_i && rdy_o.
- rdy_o  out  1  idle, able to accept a transaction.
- data_i  in  CMD_WORDS*WORD_BITS  payload; word k = data_i[k*WORD_BITS +: WORD_BITS].
- nwords_i  in  $clog2(CMD_WORDS)  words to send minus one.
- div_i  in  DIV_BITS  clock cycles per bit; values 0 and 1 are treated as 2.
- parity_i  in  2  00 none, 01 odd, 10 even, 11 treated as none.
- stop2_i  in  1  0: one stop bit, 1: two stop bits.
- xoff_i  in  1  host flow control; pauses between words.
- tx_o  out  1  serial line, idle high.
- done_o  out  1  one-cycle pulse at transaction completion.

Behaviour:
- Clocking and reset:
  - Single clock. Reset is synchronous, active-high, and takes effect in the cycle it is sampled, including mid-frame.
  - Reset values: tx_o=1, rdy_o=1, done_o=0, FSM=IDLE, all counters 0.
- Accept:
  - On the edge where stb_i && rdy_o, latch data_i, nwords_i, the effective div_i, parity_i and stop2_i.
  - In the following cycle, rdy_o=0 and the start bit begins (tx_o=0).
  - stb_i while rdy_o=0 is ignored. Input changes after accept have no effect.
- Bit timing:
  - Every bit (start, data, parity, stop) holds tx_o for exactly DIV cycles, where DIV is the latched effective divisor.
  - A down-counter reloads DIV-1 at each bit boundary.
- FSM states: IDLE, START, DATA, PARITY, STOP, HOLD.
- Transitions:
  - IDLE -> START on accept.
  - START -> DATA after DIV cycles.
  - DATA sends WORD_BITS bits, LSB first, then goes to PARITY if parity is enabled, else to STOP.
  - PARITY sends one bit:
    - even: XOR of the data bits.
    - odd: its inverse.
  - STOP holds tx_o=1 for DIV cycles, or 2*DIV cycles if stop2 is set.
- End of stop:
  - If this was the last word (word index == latched nwords), go to IDLE: done_o=1 and rdy_o=1 in that same cycle; tx_o stays 1.
  - Else, if xoff_i is high in the final stop cycle, go to HOLD with tx_o=1.
  - Else, go to START of the next word with no gap.
- HOLD -> START in the cycle after xoff_i is sampled low.
- xoff_i never interrupts a frame in progress and is ignored after the last word and in IDLE.
- Frame length per word: (1 + WORD_BITS + P + S) * DIV cycles, where P is 0 or 1 and S is 1 or 2.
- Total idle-to-idle time without XOFF: (nwords+1) * frame length.
- done_o is never asserted except for one cycle per completed transaction. An accept in the same cycle done_o/rdy_o rise is legal and starts the next start bit the following cycle.
- Reset during HOLD or mid-frame: tx_o returns to 1 the next cycle, no done_o.

Test Plan:
- Reset: assert rst_i 3 cycles while stb_i=1 -> tx_o=1, rdy_o=1, done_o=0 throughout. First accept after release is honoured.
- Single word, 8N1 frame: div=5, nwords=0, parity=00, stop2=0, data word0=0xA5 -> tx_o bit sequence 0,1,0,1,0,0,1,0,1,1, each bit held 5 cycles. done_o pulses at cycle 50 after accept, together with rdy_o rise.
- Four words, even parity, two stop bits: div=4, nwords=3, data=0x01_80_FF_00 (word0=0x00) -> parity bits 0,0,1,1 for words 0..3. Each frame is 48 cycles; done_o at cycle 192; tx_o never low between frames.
- XOFF pause: div=5, nwords=1, xoff_i raised mid word0 -> word0 completes intact, tx_o stays high in HOLD. Lowering xoff_i starts word1's start bit the next cycle. xoff_i raised during word1 has no effect.
- Divisor clamp: div_i=0 and div_i=1, one word 0x3C -> each bit lasts 2 cycles, frame of 20 cycles.
- Reset mid-frame and busy strobe:
  - stb_i pulsed during transmission -> ignored, payload unchanged.
  - rst_i asserted during data bit 3 -> tx_o=1 and rdy_o=1 the next cycle, no done_o.
  - A new transaction then runs cleanly.
